// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment codes, converter states and helpers for seg7_scan_display
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_SHIFT,
        CONV_DONE
    } conv_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        case (nibble)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter, one input bit per clock
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int BIN_W  = 13,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BIN_W-1:0]      num,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam longint unsigned LIMIT = pow10(DIGITS);
    // When every BIN_W-bit value fits in DIGITS decimals the comparator folds away.
    localparam bit OVF_POSSIBLE = (BIN_W >= 64) || (LIMIT < (64'd1 << BIN_W));
    localparam logic [BIN_W-1:0] LIMIT_W = OVF_POSSIBLE ? BIN_W'(LIMIT) : '0;

    conv_state_t      state;
    logic [BIN_W-1:0] shreg;
    logic [BCD_W-1:0] acc;
    logic [BCD_W-1:0] acc_adj;
    logic [CNT_W-1:0] bit_cnt;
    logic             ovf_pending;

    assign busy = (state != CONV_IDLE);

    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CONV_IDLE;
            shreg       <= '0;
            acc         <= '0;
            bit_cnt     <= '0;
            ovf_pending <= 1'b0;
            done        <= 1'b0;
            bcd         <= '0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                CONV_IDLE: begin
                    if (load) begin
                        shreg       <= num;
                        acc         <= '0;
                        bit_cnt     <= '0;
                        ovf_pending <= OVF_POSSIBLE && (num >= LIMIT_W);
                        state       <= CONV_SHIFT;
                    end
                end
                CONV_SHIFT: begin
                    // Carries out of the top nibble are dropped; ovf_pending covers them.
                    acc     <= {acc_adj[BCD_W-2:0], shreg[BIN_W-1]};
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(BIN_W - 1)) state <= CONV_DONE;
                end
                CONV_DONE: begin
                    bcd      <= acc;
                    overflow <= ovf_pending;
                    done     <= 1'b1;
                    state    <= CONV_IDLE;
                end
                default: state <= CONV_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - multiplexed common-anode display driver with BCD conversion
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int BIN_W     = 13,
    parameter int DIGITS    = 4,
    parameter int REFRESH_W = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [BIN_W-1:0]  num,
    input  logic              blank_lz,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [DIGITS-1:0] anode,
    output logic [6:0]        seg
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0]  disp;
    logic [REFRESH_W-1:0] refresh_cnt;
    logic [IDX_W-1:0]     digit_idx;
    logic [3:0]           cur_nibble;
    logic                 cur_lz;
    logic                 zero_above;
    logic [6:0]           seg_next;

    bin2bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .num      (num),
        .busy     (busy),
        .done     (done),
        .bcd      (disp),
        .overflow (overflow)
    );

    // Walk from the top digit down so zero_above means "this digit and all above are zero".
    always_comb begin
        zero_above = 1'b1;
        cur_nibble = '0;
        cur_lz     = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (disp[4*k +: 4] == 4'd0);
            if (digit_idx == IDX_W'(k)) begin
                cur_nibble = disp[4*k +: 4];
                cur_lz     = zero_above && (k != 0);
            end
        end
        if (overflow)                seg_next = SEG_DASH;
        else if (blank_lz && cur_lz) seg_next = SEG_BLANK;
        else                         seg_next = seg_decode(cur_nibble);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            anode       <= '1;
            seg         <= SEG_BLANK;
        end else begin
            refresh_cnt <= refresh_cnt + REFRESH_W'(1);
            if (refresh_cnt == '1) begin
                digit_idx <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
            end
            anode <= ~(DIGITS'(1) << digit_idx);
            seg   <= seg_next;
        end
    end

endmodule
